// File: rtl/sdram_arb_defs.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arb_defs (package)
//  Purpose  : Shared encodings for the SDRAM host-port arbiter: FSM states,
//             requester port ids and the halfword-address helper.
//  Revision : 1.0 - initial release
// ============================================================================
package sdram_arb_defs;

    // FSM state encodings
    localparam int         c_STATE_W  = 3;
    localparam logic [2:0] c_ST_DRAIN = 3'd0;
    localparam logic [2:0] c_ST_IDLE  = 3'd1;
    localparam logic [2:0] c_ST_LO    = 3'd2;
    localparam logic [2:0] c_ST_HI    = 3'd3;
    localparam logic [2:0] c_ST_ACK   = 3'd4;

    // Requester port ids
    localparam logic c_PORT_I = 1'b0;
    localparam logic c_PORT_D = 1'b1;

    // Halfword address of the low (hi=0) or high (hi=1) half of a 32-bit word
    function automatic logic [30:0] f_half_addr(input logic [29:0] word_addr,
                                                input logic        hi);
        return {word_addr, hi};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_arb_grant.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arb_grant
//  Purpose  : Chooses which CPU port is served next and remembers the port
//             of the most recent grant (which is also the port owning the
//             request currently in flight).
//  Config   : SDRAM_ARB_ROUND_ROBIN_EN - defined: round-robin on ties;
//             undefined: data port always wins ties.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_arb_grant
    import sdram_arb_defs::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_i,       // instruction port requesting
    input  logic i_req_d,       // data port requesting
    input  logic i_take,        // the current choice is being granted
    output logic o_valid,       // some port is requesting
    output logic o_port,        // port that would be granted now
    output logic o_last_grant   // port of the most recent grant
);

    logic r_last_grant_q;
    logic w_last_grant_d;

    // Pick a port from the live requests; remember it when it is taken
    always_comb begin
        o_valid = i_req_i | i_req_d;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        if (i_req_i && i_req_d) begin
            o_port = (r_last_grant_q == c_PORT_I) ? c_PORT_D : c_PORT_I;
        end else begin
            o_port = i_req_d ? c_PORT_D : c_PORT_I;
        end
`else
        o_port = i_req_d ? c_PORT_D : c_PORT_I;
`endif
        w_last_grant_d = i_take ? o_port : r_last_grant_q;
    end

    // Last-grant register; resets to instruction so data wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant_q <= c_PORT_I;
        end else begin
            r_last_grant_q <= w_last_grant_d;
        end
    end

    assign o_last_grant = r_last_grant_q;

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arbiter
//  Purpose  : Shares one 16-bit SDRAM controller host port between the CPU
//             instruction and data buses. Each 32-bit request is split into
//             up to two 16-bit accesses (low half first) and acknowledged
//             once with the assembled read data.
//  Config   : SDRAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration
//             (see sdram_arb_grant); default is fixed data-port priority.
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter
    import sdram_arb_defs::*;
#(
    parameter int DRAIN_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    // instruction bus
    input  logic        i_access,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_wr_en,
    input  logic [3:0]  i_bytesel,
    output logic [31:0] i_data,
    output logic        i_ack,
    // data bus
    input  logic        d_access,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_wr_en,
    input  logic [3:0]  d_bytesel,
    output logic [31:0] d_data,
    output logic        d_ack,
    // SDRAM controller host port
    output logic [30:0] h_addr,
    output logic [15:0] h_wdata,
    input  logic [15:0] h_rdata,
    output logic        h_wr_en,
    output logic [1:0]  h_bytesel,
    input  logic        h_compl,
    input  logic        h_config_done
);

    localparam int                    c_DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [c_DRAIN_W-1:0]  c_DRAIN_LAST = c_DRAIN_W'(DRAIN_CYCLES - 1);

    logic [c_STATE_W-1:0] r_state_q,   w_state_d;
    logic [c_DRAIN_W-1:0] r_drain_q,   w_drain_d;
    logic [29:0]          r_addr_q,    w_addr_d;
    logic [31:0]          r_wdata_q,   w_wdata_d;
    logic                 r_wr_en_q,   w_wr_en_d;
    logic [3:0]           r_bytesel_q, w_bytesel_d;
    logic [31:0]          r_data_q,    w_data_d;
    logic [31:0]          r_i_data_q,  w_i_data_d;
    logic [31:0]          r_d_data_q,  w_d_data_d;

    logic w_grant_valid;
    logic w_grant_port;
    logic w_active_port;
    logic w_take;

    // Byte-lane bits of the CPU addresses have no meaning for halfword accesses
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = &{1'b0, i_addr[1:0], d_addr[1:0]};

    sdram_arb_grant u_grant (
        .clk          (clk),
        .rst          (rst),
        .i_req_i      (i_access),
        .i_req_d      (d_access),
        .i_take       (w_take),
        .o_valid      (w_grant_valid),
        .o_port       (w_grant_port),
        .o_last_grant (w_active_port)
    );

    assign w_take = (r_state_q == c_ST_IDLE) && h_config_done && w_grant_valid;

    // Next-state, request latching and read-data assembly
    always_comb begin
        w_state_d   = r_state_q;
        w_drain_d   = r_drain_q;
        w_addr_d    = r_addr_q;
        w_wdata_d   = r_wdata_q;
        w_wr_en_d   = r_wr_en_q;
        w_bytesel_d = r_bytesel_q;
        w_data_d    = r_data_q;
        w_i_data_d  = r_i_data_q;
        w_d_data_d  = r_d_data_q;

        case (r_state_q)
            c_ST_DRAIN: begin
                // h_compl is deliberately ignored while a stale access drains
                if (r_drain_q == c_DRAIN_LAST) begin
                    w_state_d = c_ST_IDLE;
                end else begin
                    w_drain_d = r_drain_q + c_DRAIN_W'(1);
                end
            end
            c_ST_IDLE: begin
                if (w_take) begin
                    w_addr_d    = (w_grant_port == c_PORT_D) ? d_addr[31:2] : i_addr[31:2];
                    w_wdata_d   = (w_grant_port == c_PORT_D) ? d_wdata      : i_wdata;
                    w_wr_en_d   = (w_grant_port == c_PORT_D) ? d_wr_en      : i_wr_en;
                    w_bytesel_d = (w_grant_port == c_PORT_D) ? d_bytesel    : i_bytesel;
                    w_data_d    = 32'h0;
                    if (w_bytesel_d[1:0] != 2'b00) begin
                        w_state_d = c_ST_LO;
                    end else if (w_bytesel_d[3:2] != 2'b00) begin
                        w_state_d = c_ST_HI;
                    end else begin
                        w_state_d = c_ST_ACK;
                    end
                end
            end
            c_ST_LO: begin
                if (h_compl) begin
                    if (!r_wr_en_q) begin
                        w_data_d[15:0] = h_rdata;
                    end
                    w_state_d = (r_bytesel_q[3:2] != 2'b00) ? c_ST_HI : c_ST_ACK;
                end
            end
            c_ST_HI: begin
                if (h_compl) begin
                    if (!r_wr_en_q) begin
                        w_data_d[31:16] = h_rdata;
                    end
                    w_state_d = c_ST_ACK;
                end
            end
            c_ST_ACK: begin
                // Keep the returned word visible on the port until its next ack
                if (w_active_port == c_PORT_D) begin
                    w_d_data_d = r_data_q;
                end else begin
                    w_i_data_d = r_data_q;
                end
                w_state_d = c_ST_IDLE;
            end
            default: begin
                w_state_d = c_ST_DRAIN;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= c_ST_DRAIN;
            r_drain_q   <= '0;
            r_addr_q    <= '0;
            r_wdata_q   <= '0;
            r_wr_en_q   <= 1'b0;
            r_bytesel_q <= '0;
            r_data_q    <= '0;
            r_i_data_q  <= '0;
            r_d_data_q  <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_drain_q   <= w_drain_d;
            r_addr_q    <= w_addr_d;
            r_wdata_q   <= w_wdata_d;
            r_wr_en_q   <= w_wr_en_d;
            r_bytesel_q <= w_bytesel_d;
            r_data_q    <= w_data_d;
            r_i_data_q  <= w_i_data_d;
            r_d_data_q  <= w_d_data_d;
        end
    end

    // Host-port and CPU-port outputs decoded from state and latched request;
    // byte enables and write select stay low outside LO/HI so an idle
    // controller never drives the SDRAM data bus
    always_comb begin
        h_addr    = f_half_addr(r_addr_q, r_state_q == c_ST_HI);
        h_wdata   = (r_state_q == c_ST_HI) ? r_wdata_q[31:16] : r_wdata_q[15:0];
        h_bytesel = 2'b00;
        h_wr_en   = 1'b0;
        if (r_state_q == c_ST_LO) begin
            h_bytesel = r_bytesel_q[1:0];
            h_wr_en   = r_wr_en_q;
        end else if (r_state_q == c_ST_HI) begin
            h_bytesel = r_bytesel_q[3:2];
            h_wr_en   = r_wr_en_q;
        end
        i_ack  = (r_state_q == c_ST_ACK) && (w_active_port == c_PORT_I);
        d_ack  = (r_state_q == c_ST_ACK) && (w_active_port == c_PORT_D);
        i_data = i_ack ? r_data_q : r_i_data_q;
        d_data = d_ack ? r_data_q : r_d_data_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_arbiter
//  Purpose  : Self-checking bench for sdram_arbiter: directed scenarios with
//             literal expectations, then randomized traffic against a
//             transaction-level model. A small controller model answers
//             host-port accesses.
//  Config   : follows SDRAM_ARB_ROUND_ROBIN_EN for the arbitration rule.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_access, i_wr_en, i_ack;
    logic [31:0] i_addr, i_wdata, i_data;
    logic [3:0]  i_bytesel;
    logic        d_access, d_wr_en, d_ack;
    logic [31:0] d_addr, d_wdata, d_data;
    logic [3:0]  d_bytesel;
    logic [30:0] h_addr;
    logic [15:0] h_wdata, h_rdata;
    logic        h_wr_en, h_compl, h_config_done;
    logic [1:0]  h_bytesel;

    always #5 clk = ~clk;

    sdram_arbiter #(.DRAIN_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .i_access(i_access), .i_addr(i_addr), .i_wdata(i_wdata), .i_wr_en(i_wr_en),
        .i_bytesel(i_bytesel), .i_data(i_data), .i_ack(i_ack),
        .d_access(d_access), .d_addr(d_addr), .d_wdata(d_wdata), .d_wr_en(d_wr_en),
        .d_bytesel(d_bytesel), .d_data(d_data), .d_ack(d_ack),
        .h_addr(h_addr), .h_wdata(h_wdata), .h_rdata(h_rdata), .h_wr_en(h_wr_en),
        .h_bytesel(h_bytesel), .h_compl(h_compl), .h_config_done(h_config_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model (transaction level) ----------------
    int          m_drain;      // cycles of drain still to run
    bit          m_have;       // a request is owned by the arbiter
    bit          m_ack;        // the current cycle is the ack cycle
    logic        m_port, m_last, m_wr;
    logic [31:0] m_addr, m_wdata, m_data, m_ihold, m_dhold;
    logic [3:0]  m_bs;
    int          m_halves[$];  // halves still to access, 0=low 1=high

    // ---------------- controller model and logs ----------------
    bit          ctl_busy;
    int          ctl_dly;
    int          ctl_fixed;    // <0: random access time
    bit          spur_en;
    logic [15:0] rd_q[$];
    logic [30:0] lg_addr[$];
    logic [1:0]  lg_bs[$];
    logic [15:0] lg_wd[$];
    logic        lg_we[$];
    logic        ack_port[$];
    logic [31:0] ack_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int hf;
        if (rst) begin
            m_drain = 16; m_have = 0; m_ack = 0; m_last = 1'b0;
            m_ihold = 0; m_dhold = 0; m_data = 0; m_halves.delete();
        end else if (m_drain > 0) begin
            m_drain--;
        end else if (m_ack) begin
            m_ack = 0; m_have = 0;
            if (m_port) m_dhold = m_data; else m_ihold = m_data;
        end else if (!m_have) begin
            if (h_config_done && (i_access || d_access)) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
                if (i_access && d_access) m_port = ~m_last;
                else                      m_port = d_access;
`else
                m_port = d_access;
`endif
                m_last  = m_port;
                m_addr  = m_port ? d_addr    : i_addr;
                m_wdata = m_port ? d_wdata   : i_wdata;
                m_wr    = m_port ? d_wr_en   : i_wr_en;
                m_bs    = m_port ? d_bytesel : i_bytesel;
                m_data  = 0;
                m_have  = 1;
                m_halves.delete();
                if (m_bs[1:0] != 0) m_halves.push_back(0);
                if (m_bs[3:2] != 0) m_halves.push_back(1);
                if (m_halves.size() == 0) m_ack = 1;
            end
        end else if (h_compl) begin
            hf = m_halves.pop_front();
            if (!m_wr) begin
                if (hf == 0) m_data[15:0] = h_rdata;
                else         m_data[31:16] = h_rdata;
            end
            if (m_halves.size() == 0) m_ack = 1;
        end
    endtask

    task automatic check_outputs();
        logic [1:0] ebs;
        logic       ewe;
        int         hf;
        ebs = 2'b00; ewe = 1'b0;
        if (m_drain == 0 && m_have && !m_ack && m_halves.size() > 0) begin
            hf  = m_halves[0];
            ebs = (hf != 0) ? m_bs[3:2] : m_bs[1:0];
            ewe = m_wr;
            check("h_addr", {1'b0, h_addr}, {1'b0, m_addr[31:2], hf[0]});
            check("h_wdata", {16'h0, h_wdata}, (hf != 0) ? {16'h0, m_wdata[31:16]} : {16'h0, m_wdata[15:0]});
        end
        check("h_bytesel", {30'h0, h_bytesel}, {30'h0, ebs});
        check("h_wr_en", {31'h0, h_wr_en}, {31'h0, ewe});
        check("i_ack", {31'h0, i_ack}, {31'h0, (m_ack && !m_port)});
        check("d_ack", {31'h0, d_ack}, {31'h0, (m_ack && m_port)});
        check("i_data", i_data, (m_ack && !m_port) ? m_data : m_ihold);
        check("d_data", d_data, (m_ack && m_port) ? m_data : m_dhold);
        if (i_ack === 1'b1) begin ack_port.push_back(1'b0); ack_data.push_back(i_data); end
        if (d_ack === 1'b1) begin ack_port.push_back(1'b1); ack_data.push_back(d_data); end
    endtask

    task automatic controller_update();
        if (h_compl) h_compl = 1'b0;
        if (!ctl_busy && !rst && (h_bytesel != 2'b00)) begin
            ctl_busy = 1;
            ctl_dly  = (ctl_fixed >= 0) ? ctl_fixed : int'($urandom_range(0, 3));
            lg_addr.push_back(h_addr); lg_bs.push_back(h_bytesel);
            lg_wd.push_back(h_wdata);  lg_we.push_back(h_wr_en);
        end
        if (ctl_busy) begin
            if (ctl_dly == 0) begin
                h_compl  = 1'b1;
                h_rdata  = (rd_q.size() > 0) ? rd_q.pop_front() : 16'($urandom);
                ctl_busy = 0;
            end else begin
                ctl_dly--;
            end
        end else if (spur_en && !h_compl && (h_bytesel == 2'b00) && $urandom_range(0, 7) == 0) begin
            h_compl = 1'b1;
            h_rdata = 16'($urandom);
        end
    endtask

    // One clock: inputs already set by the caller apply at the next posedge
    task automatic tick();
        controller_update();
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_until_ack(input string name, input int max_cycles);
        int start, n;
        start = ack_port.size(); n = 0;
        while (ack_port.size() == start && n < max_cycles) begin
            tick(); n++;
        end
        n_cmp++;
        if (ack_port.size() == start) begin
            n_bad++;
            $display("FAIL %s: no ack within %0d cycles (got none, required one)", name, max_cycles);
        end
    endtask

    task automatic clear_logs();
        lg_addr.delete(); lg_bs.delete(); lg_wd.delete(); lg_we.delete();
        ack_port.delete(); ack_data.delete();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int k = 0; k < cycles; k++) tick();
        rst = 1'b0;
    endtask

    task automatic idle_ports();
        i_access = 0; i_addr = 0; i_wdata = 0; i_wr_en = 0; i_bytesel = 0;
        d_access = 0; d_addr = 0; d_wdata = 0; d_wr_en = 0; d_bytesel = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nz, base;
        rst = 1'b1; h_compl = 1'b0; h_rdata = 16'h0; h_config_done = 1'b1;
        ctl_busy = 0; ctl_dly = 0; ctl_fixed = 2; spur_en = 0;
        idle_ports();

        // ---- reset values ----
        do_reset(2);
        check("rst_h_bytesel", {30'h0, h_bytesel}, 32'h0);
        check("rst_h_addr", {1'b0, h_addr}, 32'h0);
        check("rst_h_wdata", {16'h0, h_wdata}, 32'h0);
        check("rst_h_wr_en", {31'h0, h_wr_en}, 32'h0);
        check("rst_d_data", d_data, 32'h0);
        check("rst_i_ack", {31'h0, i_ack}, 32'h0);

        // ---- drain window, then full read on the data port ----
        clear_logs();
        rd_q = '{16'h1234, 16'h5678};
        d_access = 1; d_addr = 32'h100; d_bytesel = 4'hF; d_wr_en = 0; d_wdata = 32'hDEAD_BEEF;
        nz = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (h_bytesel !== 2'b00) nz++;
        end
        check("drain_no_access", nz, 0);
        run_until_ack("full_read", 60);
        d_access = 0;
        check("full_read_n_acc", lg_addr.size(), 2);
        if (lg_addr.size() == 2) begin
            check("full_read_addr0", {1'b0, lg_addr[0]}, 32'h80);
            check("full_read_addr1", {1'b0, lg_addr[1]}, 32'h81);
        end
        if (ack_data.size() > 0) begin
            check("full_read_data", ack_data[0], 32'h5678_1234);
            check("full_read_port", {31'h0, ack_port[0]}, 32'h1);
        end
        tick();
        check("full_read_ack_1cyc", {31'h0, d_ack}, 32'h0);
        check("full_read_hold", d_data, 32'h5678_1234);

        // ---- single-byte write on the instruction port ----
        clear_logs();
        i_access = 1; i_addr = 32'h202; i_bytesel = 4'b0100; i_wdata = 32'hAB00_0000; i_wr_en = 1;
        run_until_ack("byte_write", 60);
        i_access = 0;
        check("byte_write_n_acc", lg_addr.size(), 1);
        if (lg_addr.size() == 1) begin
            check("byte_write_addr", {1'b0, lg_addr[0]}, 32'h101);
            check("byte_write_bs", {30'h0, lg_bs[0]}, 32'h1);
            check("byte_write_wdata", {16'h0, lg_wd[0]}, 32'hAB00);
            check("byte_write_we", {31'h0, lg_we[0]}, 32'h1);
        end
        check("byte_write_we_after", {31'h0, h_wr_en}, 32'h0);
        if (ack_data.size() > 0) check("byte_write_data", ack_data[0], 32'h0);

        // ---- zero-byte request ----
        tick();
        clear_logs();
        d_access = 1; d_addr = 32'h444; d_bytesel = 4'h0; d_wr_en = 0;
        run_until_ack("zero_byte", 10);
        d_access = 0;
        check("zero_byte_n_acc", lg_addr.size(), 0);
        if (ack_data.size() > 0) check("zero_byte_data", ack_data[0], 32'h0);

        // ---- reset during the low-half access ----
        tick();
        clear_logs();
        ctl_fixed = 3;
        d_access = 1; d_addr = 32'h300; d_bytesel = 4'hF; d_wr_en = 0;
        for (int k = 0; k < 10 && lg_addr.size() == 0; k++) tick();
        check("rst_mid_started", lg_addr.size(), 1);
        do_reset(1);
        d_access = 0;
        for (int k = 0; k < 20; k++) tick();
        check("rst_mid_no_ack", ack_port.size(), 0);
        ctl_fixed = 2;
        rd_q = '{16'h1111, 16'h2222};
        d_access = 1; d_addr = 32'h400;
        run_until_ack("after_rst", 60);
        d_access = 0;
        if (ack_data.size() > 0) check("after_rst_data", ack_data[0], 32'h2222_1111);

        // ---- contention from reset ----
        tick();
        do_reset(1);
        clear_logs();
        i_access = 1; i_addr = 32'h1000; i_bytesel = 4'h3; i_wr_en = 0;
        d_access = 1; d_addr = 32'h2000; d_bytesel = 4'hC; d_wr_en = 0;
        for (int k = 0; k < 400 && ack_port.size() < 8; k++) tick();
        check("contend_n_acks", ack_port.size(), 8);
        for (int k = 0; k < 8 && k < ack_port.size(); k++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            check("contend_rr_port", {31'h0, ack_port[k]}, (k % 2 == 0) ? 32'h1 : 32'h0);
`else
            check("contend_fixed_port", {31'h0, ack_port[k]}, 32'h1);
`endif
        end
        idle_ports();
        tick();

        // ---- randomized traffic against the model ----
        ctl_fixed = -1; spur_en = 1;
        base = n_cmp;
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            h_config_done = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 3) == 0) begin
                i_addr = $urandom; i_wdata = $urandom;
                i_wr_en = $urandom_range(0, 1); i_bytesel = 4'($urandom_range(0, 15));
            end
            i_access = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 3) == 0) begin
                d_addr = $urandom; d_wdata = $urandom;
                d_wr_en = $urandom_range(0, 1); d_bytesel = 4'($urandom_range(0, 15));
            end
            d_access = ($urandom_range(0, 9) < 6);
            tick();
        end
        rst = 1'b0;
        check("random_ran", (n_cmp - base) > 3000, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
